// File: rtl/trees_driver.sv
// Stream front-end for the trees engine: loads node words into the forest,
// then packs feature samples, runs one inference and returns the class.
module trees_driver #(
  parameter int N_TREES          = 16,
  parameter int N_NODE_AND_LEAFS = 256,
  parameter int N_FEATURE        = 32
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  cfg_load,
  input  logic [63:0]                           s_data,
  input  logic                                  s_valid,
  output logic                                  s_ready,
  output logic                                  model_loaded,
  output logic                                  load_trees,
  output logic [$clog2(N_TREES)-1:0]            n_tree,
  output logic [$clog2(N_NODE_AND_LEAFS)-1:0]   n_node,
  output logic [63:0]                           tree_nodes,
  output logic [N_FEATURE*32-1:0]               features,
  output logic                                  start,
  input  logic [7:0]                            prediction,
  input  logic                                  done,
  input  logic                                  idle_sys,
  output logic [7:0]                            m_pred,
  output logic                                  m_valid,
  input  logic                                  m_ready,
  output logic                                  busy
);

  localparam int TW      = $clog2(N_TREES);
  localparam int NW      = $clog2(N_NODE_AND_LEAFS);
  localparam int N_WORDS = N_FEATURE / 2;
  localparam int WW      = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;

  localparam logic [TW-1:0] LAST_TREE = TW'(N_TREES - 1);
  localparam logic [NW-1:0] LAST_NODE = NW'(N_NODE_AND_LEAFS - 1);
  localparam logic [WW-1:0] LAST_WORD = WW'(N_WORDS - 1);

  typedef enum logic [2:0] {IDLE, LOAD, FEAT, START, WAIT, OUT} state_t;

  state_t          state_reg, state_next;
  logic [TW-1:0]   tree_cnt_reg;
  logic [NW-1:0]   node_cnt_reg;
  logic [WW-1:0]   word_cnt_reg;
  logic            model_loaded_reg;
  logic            load_trees_reg;
  logic [TW-1:0]   n_tree_reg;
  logic [NW-1:0]   n_node_reg;
  logic [63:0]     tree_nodes_reg;
  logic [7:0]      m_pred_reg;

  logic last_node;
  assign last_node = (tree_cnt_reg == LAST_TREE) && (node_cnt_reg == LAST_NODE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    s_ready    = 1'b0;
    start      = 1'b0;
    m_valid    = 1'b0;
    busy       = 1'b1;
    case (state_reg)
      IDLE: begin
        busy = 1'b0;
        // Reload takes priority over a waiting sample.
        if (cfg_load)                         state_next = LOAD;
        else if (s_valid && model_loaded_reg) state_next = FEAT;
      end
      LOAD: begin
        s_ready = 1'b1;
        if (s_valid && last_node) state_next = IDLE;
      end
      FEAT: begin
        s_ready = 1'b1;
        if (s_valid && (word_cnt_reg == LAST_WORD)) state_next = START;
      end
      START: begin
        if (idle_sys) begin
          start      = 1'b1;
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (done) state_next = OUT;
      end
      OUT: begin
        m_valid = 1'b1;
        if (m_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tree_cnt_reg     <= '0;
      node_cnt_reg     <= '0;
      word_cnt_reg     <= '0;
      model_loaded_reg <= 1'b0;
      load_trees_reg   <= 1'b0;
      n_tree_reg       <= '0;
      n_node_reg       <= '0;
      tree_nodes_reg   <= '0;
      m_pred_reg       <= '0;
    end else begin
      load_trees_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (cfg_load) begin
            model_loaded_reg <= 1'b0;
            tree_cnt_reg     <= '0;
            node_cnt_reg     <= '0;
          end else if (s_valid && model_loaded_reg) begin
            word_cnt_reg <= '0;
          end
        end
        LOAD: begin
          if (s_valid) begin
            tree_nodes_reg <= s_data;
            n_tree_reg     <= tree_cnt_reg;
            n_node_reg     <= node_cnt_reg;
            load_trees_reg <= 1'b1;
            if (node_cnt_reg == LAST_NODE) begin
              node_cnt_reg <= '0;
              tree_cnt_reg <= (tree_cnt_reg == LAST_TREE) ? '0 : tree_cnt_reg + 1'b1;
              if (tree_cnt_reg == LAST_TREE) model_loaded_reg <= 1'b1;
            end else begin
              node_cnt_reg <= node_cnt_reg + 1'b1;
            end
          end
        end
        FEAT: begin
          if (s_valid) word_cnt_reg <= word_cnt_reg + 1'b1;
        end
        WAIT: begin
          if (done) m_pred_reg <= prediction;
        end
        default: ;
      endcase
    end
  end

  // Each stream word carries a feature pair; only FEAT accepts may touch them.
  genvar gi;
  generate
    for (gi = 0; gi < N_WORDS; gi++) begin : g_feat
      logic [63:0] pair_reg;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
          pair_reg <= '0;
        else if ((state_reg == FEAT) && s_valid && (word_cnt_reg == WW'(gi)))
          pair_reg <= s_data;
      end
      assign features[64*gi +: 64] = pair_reg;
    end
  endgenerate

  assign model_loaded = model_loaded_reg;
  assign load_trees   = load_trees_reg;
  assign n_tree       = n_tree_reg;
  assign n_node       = n_node_reg;
  assign tree_nodes   = tree_nodes_reg;
  assign m_pred       = m_pred_reg;

endmodule

// File: tb/tb_trees_driver.sv
// Directed bench for trees_driver with a 2-tree, 4-node, 4-feature build:
// reset, plain and backpressured loads, inference handshakes and corner cases.
module tb_trees_driver;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cfg_load;
  logic [63:0]   s_data;
  logic          s_valid;
  logic          s_ready;
  logic          model_loaded;
  logic          load_trees;
  logic [0:0]    n_tree;
  logic [1:0]    n_node;
  logic [63:0]   tree_nodes;
  logic [127:0]  features;
  logic          start;
  logic [7:0]    prediction;
  logic          done;
  logic          idle_sys;
  logic [7:0]    m_pred;
  logic          m_valid;
  logic          m_ready;
  logic          busy;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  trees_driver #(.N_TREES(2), .N_NODE_AND_LEAFS(4), .N_FEATURE(4)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_load(cfg_load),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .model_loaded(model_loaded), .load_trees(load_trees),
    .n_tree(n_tree), .n_node(n_node), .tree_nodes(tree_nodes),
    .features(features), .start(start), .prediction(prediction),
    .done(done), .idle_sys(idle_sys), .m_pred(m_pred),
    .m_valid(m_valid), .m_ready(m_ready), .busy(busy)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic infer(input logic [63:0] w0, input logic [63:0] w1,
                       input logic [127:0] exp_feat, input logic [7:0] pred,
                       input int idle_wait, input int done_delay, input int stall);
    s_valid = 1'b1;
    s_data  = w0;
    tick();
    check("feat_s_ready", s_ready, 1);
    check("feat_busy", busy, 1);
    tick();
    s_data = w1;
    tick();
    s_valid = 1'b0;
    check("start_s_ready", s_ready, 0);
    check("features", features, exp_feat);
    for (int k = 0; k < idle_wait; k++) begin
      check("start_held", start, 0);
      tick();
    end
    idle_sys = 1'b1;
    #1;
    check("start_pulse", start, 1);
    tick();
    idle_sys = 1'b0;
    check("start_single", start, 0);
    for (int k = 0; k < done_delay; k++) begin
      check("wait_m_valid", m_valid, 0);
      check("wait_start", start, 0);
      tick();
    end
    done       = 1'b1;
    prediction = pred;
    tick();
    done       = 1'b0;
    prediction = 8'h00;
    check("m_valid", m_valid, 1);
    check("m_pred", m_pred, pred);
    check("features_held", features, exp_feat);
    s_valid = 1'b1;
    s_data  = 64'hFFFF_FFFF_FFFF_FFFF;
    for (int k = 0; k < stall; k++) begin
      tick();
      check("stall_m_valid", m_valid, 1);
      check("stall_m_pred", m_pred, pred);
      check("stall_s_ready", s_ready, 0);
    end
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    s_valid = 1'b0;
    check("consumed_m_valid", m_valid, 0);
    check("consumed_busy", busy, 0);
    $display("infer: words %h %h -> class %0d", w0, w1, m_pred);
  endtask

  initial begin
    int idx;
    int c;
    logic v;

    rst_n = 1'b0; cfg_load = 1'b0; s_data = '0; s_valid = 1'b0;
    prediction = 8'h00; done = 1'b0; idle_sys = 1'b0; m_ready = 1'b0;
    repeat (2) tick();
    check("rst_s_ready", s_ready, 0);
    check("rst_model_loaded", model_loaded, 0);
    check("rst_load_trees", load_trees, 0);
    check("rst_n_tree", n_tree, 0);
    check("rst_n_node", n_node, 0);
    check("rst_tree_nodes", tree_nodes, 0);
    check("rst_features", features, 0);
    check("rst_start", start, 0);
    check("rst_m_pred", m_pred, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;

    // Partial load interrupted by reset
    cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
    check("pl_busy", busy, 1);
    s_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      s_data = 64'h50 + 64'(i);
      tick();
      check("pl_load_trees", load_trees, 1);
    end
    rst_n = 1'b0;
    #1;
    check("mid_rst_load_trees", load_trees, 0);
    check("mid_rst_model_loaded", model_loaded, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_n_node", n_node, 0);
    check("mid_rst_tree_nodes", tree_nodes, 0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("noload_s_ready", s_ready, 0);
      check("noload_busy", busy, 0);
    end
    s_valid = 1'b0;

    // Back-to-back model load
    cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
    check("load_busy", busy, 1);
    for (int i = 0; i < 8; i++) begin
      s_valid = 1'b1;
      s_data  = 64'h100 + 64'(i);
      tick();
      check("load_strobe", load_trees, 1);
      check("load_n_tree", n_tree, i / 4);
      check("load_n_node", n_node, i % 4);
      check("load_data", tree_nodes, 64'h100 + 64'(i));
      $display("load: tree %0d node %0d data %h", n_tree, n_node, tree_nodes);
    end
    s_valid = 1'b0;
    check("loaded", model_loaded, 1);
    check("loaded_busy", busy, 0);
    tick();
    check("load_strobe_off", load_trees, 0);

    // Spurious done while idle
    done = 1'b1; prediction = 8'h55;
    tick();
    done = 1'b0; prediction = 8'h00;
    check("spur_m_valid", m_valid, 0);
    check("spur_busy", busy, 0);
    check("spur_m_pred", m_pred, 0);

    infer(64'h0000000200000001, 64'h0000000400000003,
          128'h00000004_00000003_00000002_00000001, 8'd7, 0, 5, 0);

    // Reload requested together with a sample: load must win
    cfg_load = 1'b1; s_valid = 1'b1; s_data = 64'hDEAD;
    tick();
    cfg_load = 1'b0;
    check("prio_model_loaded", model_loaded, 0);
    check("prio_busy", busy, 1);
    check("prio_load_trees", load_trees, 0);
    idx = 0;
    c = 0;
    while (idx < 8 && c < 40) begin
      v = (c % 3 != 1);
      s_valid = v;
      s_data  = 64'h200 + 64'(idx);
      tick();
      check("bp_strobe", load_trees, v);
      if (v) begin
        check("bp_n_tree", n_tree, idx / 4);
        check("bp_n_node", n_node, idx % 4);
        check("bp_data", tree_nodes, 64'h200 + 64'(idx));
        $display("bp load: tree %0d node %0d data %h", n_tree, n_node, tree_nodes);
        idx++;
      end
      c++;
    end
    s_valid = 1'b0;
    check("bp_count", idx, 8);
    check("bp_loaded", model_loaded, 1);

    infer(64'h0000002000000010, 64'h0000004000000030,
          128'h00000040_00000030_00000020_00000010, 8'd3, 3, 2, 10);

    tick();
    check("final_busy", busy, 0);
    check("final_m_valid", m_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/trees_driver.md
# trees_driver

Front-end controller for the `trees` random-forest engine. It takes one 64-bit valid/ready input stream and turns it into the engine's node-load port (`load_trees`/`n_tree`/`n_node`/`tree_nodes`) during model load. For inference it packs the stream into the `features` vector, issues `start`, waits for `done`, and returns `prediction` on an output valid/ready stream. It sits between the accelerator's DMA/stream interface and `trees`.

## Interface
- `N_TREES`, 16, number of trees; must match `trees`
- `N_NODE_AND_LEAFS`, 256, node slots per tree; must match `trees`
- `N_FEATURE`, 32, features per sample; must be even and match `trees`

Ports:
- `clk` in 1: single clock, all logic on rising edge
- `rst_n` in 1: asynchronous active-low reset
- `cfg_load` in 1: request model load; sampled only in IDLE
- `s_data` in 64: input word (node word or two packed features)
- `s_valid` in 1: input word valid
- `s_ready` out 1: input word accepted when `s_valid && s_ready`
- `model_loaded` out 1: a complete model has been written since the last `cfg_load`
- `load_trees` out 1: node write strobe to `trees`
- `n_tree` out $clog2(N_TREES): tree index of write
- `n_node` out $clog2(N_NODE_AND_LEAFS): node index of write
- `tree_nodes` out 64: node word of write
- `features` out N_FEATURE×32: feature vector to `trees`
- `start` out 1: one-cycle inference start to `trees`
- `prediction` in 8: class from `trees`
- `done` in 1: one-cycle completion pulse from `trees`
- `idle_sys` in 1: `trees` vote FSM idle
- `m_pred` out 8: predicted class
- `m_valid` out 1: result valid
- `m_ready` in 1: result consumed when `m_valid && m_ready`
- `busy` out 1: FSM not in IDLE

## Operation
- FSM states: IDLE, LOAD, FEAT, START, WAIT, OUT.
- **IDLE**
  - `s_ready=0`.
  - If `cfg_load`: go to LOAD, clear `model_loaded`, zero the tree and node counters. `cfg_load` has priority over a pending sample.
  - Else if `s_valid && model_loaded`: go to FEAT with word counter 0.
  - `s_valid` with `model_loaded=0` stalls with no acceptance.
- **LOAD**
  - `s_ready=1`.
  - Each accepted word registers `tree_nodes<=s_data`, `n_tree<=tree_cnt`, `n_node<=node_cnt`, `load_trees<=1`. `load_trees` is 0 in every cycle with no accept.
  - `node_cnt` increments; at N_NODE_AND_LEAFS-1 it wraps to 0 and `tree_cnt` increments.
  - On accepting the word with tree N_TREES-1, node N_NODE_AND_LEAFS-1: set `model_loaded`, go to IDLE.
- **FEAT**
  - `s_ready=1`.
  - Accepted word k (0..N_FEATURE/2-1) writes `features[2k]<=s_data[31:0]` and `features[2k+1]<=s_data[63:32]`.
  - After word N_FEATURE/2-1: go to START.
- **START**
  - `s_ready=0`.
  - When `idle_sys==1`: `start=1` for exactly that cycle, then go to WAIT.
- **WAIT**
  - On `done==1`: capture `m_pred<=prediction`, go to OUT.
  - `features` is held stable from START through WAIT.
- **OUT**
  - `m_valid=1`, `m_pred` stable until accepted.
  - On `m_ready`: `m_valid<=0`, go to IDLE.
- `done` outside WAIT is ignored.
- `cfg_load` outside IDLE is ignored, not queued.
- `features` keeps its last values outside FEAT; it is never cleared except by reset.

## Timing
- Reset values:
  - FSM=IDLE, all counters 0.
  - `s_ready=0`, `model_loaded=0`, `load_trees=0`, `n_tree=0`, `n_node=0`, `tree_nodes=0`.
  - `features` all 0, `start=0`, `m_pred=0`, `m_valid=0`, `busy=0`.
- Reset mid-operation returns to the above immediately. A partial model leaves `model_loaded=0`.
- Write latency: `load_trees` and write fields are asserted the cycle after the accept; back-to-back accepts give back-to-back strobes.
- Load: with continuous `s_valid`, N_TREES·N_NODE_AND_LEAFS accepts in as many consecutive cycles. IDLE→LOAD costs 1 cycle.
- Inference:
  - IDLE→FEAT costs 1 cycle; FEAT takes N_FEATURE/2 cycles with `s_valid` held.
  - START asserts `start` the first cycle `idle_sys=1`.
  - `m_valid` rises the cycle after `done`.
- Throughput: a new sample is not accepted until the result is consumed (one sample in flight).
- `busy=1` in every state except IDLE.

## Test plan
Use N_TREES=2, N_NODE_AND_LEAFS=4, N_FEATURE=4 unless stated.
- **Reset:** assert `rst_n=0` mid-LOAD -> all outputs at reset values; `model_loaded=0`; later `s_valid` in IDLE not accepted.
- **Load:** `cfg_load` then 8 words 0x100..0x107 back-to-back -> `load_trees` high 8 consecutive cycles; (n_tree,n_node) = (0,0)..(0,3),(1,0)..(1,3); `model_loaded=1` after the last accept.
- **Backpressured load:** `s_valid` toggling 1,0,1 -> `load_trees` only after accepted cycles; counters never skip or repeat.
- **Inference:**
  - Send words 0x0000000200000001 and 0x0000000400000003 -> `features` = {1,2,3,4}; `start` is a single one-cycle pulse.
  - Model `done` 5 cycles later with `prediction=7` -> `m_valid=1`, `m_pred=7` the next cycle.
- **Output stall:** hold `m_ready=0` 10 cycles -> `m_pred` stable, `s_ready=0`; next sample accepted only after `m_ready`.
- **Corner cases:**
  - `cfg_load` and `s_valid` together in IDLE -> LOAD wins.
  - `start` waits while `idle_sys=0`.
  - Spurious `done` in IDLE -> no `m_valid`.
